// File: rtl/ace_instbuf.sv
// ace_instbuf: compacting circular instruction queue between fetch (8 wide) and decode (4 wide)
module ace_instbuf #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       retire_flush_i,
    input  logic [INST_W-1:0]          fetch_inst0_i,
    input  logic [INST_W-1:0]          fetch_inst1_i,
    input  logic [INST_W-1:0]          fetch_inst2_i,
    input  logic [INST_W-1:0]          fetch_inst3_i,
    input  logic [INST_W-1:0]          fetch_inst4_i,
    input  logic [INST_W-1:0]          fetch_inst5_i,
    input  logic [INST_W-1:0]          fetch_inst6_i,
    input  logic [INST_W-1:0]          fetch_inst7_i,
    input  logic                       fetch_inst0_vld_i,
    input  logic                       fetch_inst1_vld_i,
    input  logic                       fetch_inst2_vld_i,
    input  logic                       fetch_inst3_vld_i,
    input  logic                       fetch_inst4_vld_i,
    input  logic                       fetch_inst5_vld_i,
    input  logic                       fetch_inst6_vld_i,
    input  logic                       fetch_inst7_vld_i,
    input  logic [2:0]                 decode_take_i,
    output logic [INST_W-1:0]          inst0_o,
    output logic [INST_W-1:0]          inst1_o,
    output logic [INST_W-1:0]          inst2_o,
    output logic [INST_W-1:0]          inst3_o,
    output logic                       inst0_vld_o,
    output logic                       inst1_vld_o,
    output logic                       inst2_vld_o,
    output logic                       inst3_vld_o,
    output logic                       instbuf_full_o,
    output logic                       instbuf_empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INST_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [INST_W-1:0] f_inst [8];
    logic [7:0]        f_vld;
    logic [2:0]        off [8];
    logic [3:0]        n_push;
    logic              full, push_ok;
    logic [2:0]        take_c;
    logic [CW-1:0]     n_pop, n_acc;
    logic [INST_W-1:0] head [4];
    logic [3:0]        head_vld;

    assign f_inst[0] = fetch_inst0_i;
    assign f_inst[1] = fetch_inst1_i;
    assign f_inst[2] = fetch_inst2_i;
    assign f_inst[3] = fetch_inst3_i;
    assign f_inst[4] = fetch_inst4_i;
    assign f_inst[5] = fetch_inst5_i;
    assign f_inst[6] = fetch_inst6_i;
    assign f_inst[7] = fetch_inst7_i;
    assign f_vld = {fetch_inst7_vld_i, fetch_inst6_vld_i, fetch_inst5_vld_i, fetch_inst4_vld_i,
                    fetch_inst3_vld_i, fetch_inst2_vld_i, fetch_inst1_vld_i, fetch_inst0_vld_i};

    // Each valid slot lands at wr_ptr plus the number of valid slots below it, squeezing out holes
    always_comb begin
        n_push = '0;
        for (int i = 0; i < 8; i++) begin
            off[i] = n_push[2:0];
            n_push = n_push + 4'(f_vld[i]);
        end
    end

    // Full is judged on the current count only, so a same-cycle pop never frees room for a push
    assign full    = count > CW'(DEPTH - 8);
    assign push_ok = !full;
    assign n_acc   = push_ok ? CW'(n_push) : '0;
    assign take_c  = (decode_take_i > 3'd4) ? 3'd4 : decode_take_i;
    assign n_pop   = (count < CW'(take_c)) ? count : CW'(take_c);

    // Queue storage; never reset, and writes are suppressed while reset or flush discard the queue
    always_ff @(posedge clock) begin
        if (reset_n && !retire_flush_i && push_ok)
            for (int i = 0; i < 8; i++)
                if (f_vld[i])
                    mem[wr_ptr + AW'(off[i])] <= f_inst[i];
    end

    // Pointer and occupancy update; reset outranks flush, flush outranks push and pop
    always_ff @(posedge clock) begin
        if (!reset_n || retire_flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_acc);
            rd_ptr <= rd_ptr + AW'(n_pop);
            count  <= count + n_acc - n_pop;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_head
        assign head_vld[k] = count > CW'(k);
        assign head[k]     = head_vld[k] ? mem[rd_ptr + AW'(k)] : '0;
    end

    assign inst0_o         = head[0];
    assign inst1_o         = head[1];
    assign inst2_o         = head[2];
    assign inst3_o         = head[3];
    assign inst0_vld_o     = head_vld[0];
    assign inst1_vld_o     = head_vld[1];
    assign inst2_vld_o     = head_vld[2];
    assign inst3_vld_o     = head_vld[3];
    assign instbuf_full_o  = full;
    assign instbuf_empty_o = count == '0;
    assign count_o         = count;
endmodule
